// File: rtl/arbiter_rr_n_if.sv
// ---------------------------------------------------------------------------
// arbiter_rr_n_if
//   Request/grant bundle between N bus masters and the shared-resource
//   arbiter. Vectors are indexed [0:N-1]; bit 0 is the highest fixed priority.
//
//   Signals
//     r       [0:N-1]  request vector, r[i]=1 -> requester i wants the resource
//     mode    1        0 = fixed priority, 1 = round robin
//     lock    1        1 = current holder keeps the grant while still requesting
//     g       [0:N-1]  registered one-hot grant (all-zero = no grant)
//     gvalid  1        registered, equals |g
//     gidx    IDXW     registered index of the set bit of g; 0 when g==0
//
//   Modports
//     master : requester side (drives r/mode/lock, receives the grant)
//     slave  : arbiter side   (receives r/mode/lock, drives the grant)
// ---------------------------------------------------------------------------
interface arbiter_rr_n_if #(
    parameter int N = 4
);
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;

    logic [0:N-1]    r;
    logic            mode;
    logic            lock;
    logic [0:N-1]    g;
    logic            gvalid;
    logic [IDXW-1:0] gidx;

    modport master (
        output r, mode, lock,
        input  g, gvalid, gidx
    );

    modport slave (
        input  r, mode, lock,
        output g, gvalid, gidx
    );
endinterface

// File: rtl/arbiter_rr_n.sv
// ---------------------------------------------------------------------------
// arbiter_rr_n
//   Registered N-requester arbiter with run-time selectable fixed-priority or
//   round-robin arbitration and an optional grant lock bounded by MAX_HOLD.
//   Grant appears one cycle after the request is sampled; holders can change
//   back-to-back with no idle cycle in between.
//
//   Parameters
//     N         number of requesters (>=1)
//     MAX_HOLD  max consecutive cycles one holder keeps a locked grant
//               (0 = unlimited)
//
//   Ports
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    arbiter_rr_n_if.slave : r/mode/lock in, g/gvalid/gidx out
// ---------------------------------------------------------------------------
module arbiter_rr_n #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    arbiter_rr_n_if.slave bus
);
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam int HCW  = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_reg,  state_next;
    logic [0:N-1]    g_reg,      g_next;
    logic            gvalid_reg, gvalid_next;
    logic [IDXW-1:0] gidx_reg,   gidx_next;   // also the current holder index
    logic [IDXW-1:0] ptr_reg,    ptr_next;    // round-robin search start
    logic [HCW-1:0]  hcnt_reg,   hcnt_next;   // cycles the holder has kept g

    logic            keep;        // holder keeps the grant this edge
    logic            limit_hit;   // holder wants to keep it but hit MAX_HOLD
    logic [0:N-1]    req_mask;    // requests taking part in arbitration
    logic [IDXW-1:0] base;        // search start (0 in fixed-priority mode)
    logic            win_found;
    logic [IDXW-1:0] win_idx;
    logic [IDXW-1:0] grant_idx;
    int              cand;

    // Index following idx, wrapping at N-1.
    function automatic logic [IDXW-1:0] succ(input logic [IDXW-1:0] idx);
        if (int'(idx) >= N - 1) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

    function automatic logic [0:N-1] onehot(input logic [IDXW-1:0] idx);
        logic [0:N-1] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            g_reg      <= '0;
            gvalid_reg <= 1'b0;
            gidx_reg   <= '0;
            ptr_reg    <= '0;
            hcnt_reg   <= '0;
        end else begin
            state_reg  <= state_next;
            g_reg      <= g_next;
            gvalid_reg <= gvalid_next;
            gidx_reg   <= gidx_next;
            ptr_reg    <= ptr_next;
            hcnt_reg   <= hcnt_next;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_next  = state_reg;
        g_next      = g_reg;
        gvalid_next = gvalid_reg;
        gidx_next   = gidx_reg;
        ptr_next    = ptr_reg;
        hcnt_next   = hcnt_reg;
        keep        = 1'b0;
        limit_hit   = 1'b0;
        req_mask    = bus.r;
        base        = bus.mode ? ptr_reg : '0;
        win_found   = 1'b0;
        win_idx     = '0;
        grant_idx   = '0;
        cand        = 0;

        // Lock handling: a holder at its hold limit is excluded from this one
        // arbitration so any other requester gets a turn.
        if (state_reg == GRANT && bus.r[gidx_reg] && bus.lock) begin
            if (MAX_HOLD == 0 || int'(hcnt_reg) < MAX_HOLD - 1) begin
                keep = 1'b1;
            end else begin
                limit_hit          = 1'b1;
                req_mask[gidx_reg] = 1'b0;
            end
        end

        // First set request searching base, base+1, .. wrapping around.
        // Fixed priority is the same search started at index 0.
        for (int off = 0; off < N; off++) begin
            cand = int'(base) + off;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!win_found && req_mask[cand]) begin
                win_found = 1'b1;
                win_idx   = IDXW'(cand);
            end
        end

        // A capped holder with no competitor is simply re-granted; this is a
        // fresh grant, so its hold count restarts.
        grant_idx = win_found ? win_idx : gidx_reg;

        if (keep) begin
            hcnt_next = hcnt_reg + 1'b1;
        end else if (win_found || limit_hit) begin
            state_next  = GRANT;
            g_next      = onehot(grant_idx);
            gvalid_next = 1'b1;
            gidx_next   = grant_idx;
            ptr_next    = succ(grant_idx);
            hcnt_next   = '0;
        end else begin
            state_next  = IDLE;
            g_next      = '0;
            gvalid_next = 1'b0;
            gidx_next   = '0;
            hcnt_next   = '0;
        end
    end

    assign bus.g      = g_reg;
    assign bus.gvalid = gvalid_reg;
    assign bus.gidx   = gidx_reg;

endmodule

// File: tb/tb_arbiter_rr_n.sv
// ---------------------------------------------------------------------------
// tb_arbiter_rr_n
//   Directed and randomised checks of arbiter_rr_n (N=4, MAX_HOLD=4).
//   Expected grants are queued when stimulus is driven and compared after
//   the following rising edge.
// ---------------------------------------------------------------------------
module tb_arbiter_rr_n;
    localparam int N        = 4;
    localparam int MAX_HOLD = 4;
    localparam int IDXW     = $clog2(N);

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    arbiter_rr_n_if #(.N(N)) bus ();

    arbiter_rr_n #(
        .N        (N),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [0:N-1] sb[$];

    // Reference model state
    int m_holder = -1;
    int m_ptr    = 0;
    int m_hcnt   = 0;

    task automatic check_outputs(input string tag, input logic [0:N-1] exp_g);
        logic            exp_v;
        logic [IDXW-1:0] exp_i;
        exp_v = |exp_g;
        exp_i = '0;
        for (int i = 0; i < N; i++) begin
            if (exp_g[i]) exp_i = IDXW'(i);
        end
        checks++;
        assert (bus.g === exp_g) else begin
            errors++;
            $error("FAIL %s g got=%b exp=%b", tag, bus.g, exp_g);
        end
        checks++;
        assert (bus.gvalid === exp_v) else begin
            errors++;
            $error("FAIL %s gvalid got=%b exp=%b", tag, bus.gvalid, exp_v);
        end
        checks++;
        assert (bus.gidx === exp_i) else begin
            errors++;
            $error("FAIL %s gidx got=%0d exp=%0d", tag, bus.gidx, exp_i);
        end
        $display("txn %-12s r=%b mode=%b lock=%b -> g=%b gvalid=%b gidx=%0d (exp g=%b)",
                 tag, bus.r, bus.mode, bus.lock, bus.g, bus.gvalid, bus.gidx, exp_g);
    endtask

    // Called just after a falling edge; returns just after the next one.
    task automatic step(input string tag, input logic [0:N-1] rv, input logic md,
                        input logic lk, input logic [0:N-1] exp_g);
        bus.r    = rv;
        bus.mode = md;
        bus.lock = lk;
        sb.push_back(exp_g);
        @(posedge clk);
        #1;
        check_outputs(tag, sb.pop_front());
        @(negedge clk);
    endtask

    // Behavioural reference: holder -1 means no grant.
    task automatic model_step(input logic [0:N-1] rv, input logic md, input logic lk,
                              output logic [0:N-1] e);
        logic [0:N-1] avail;
        int           start;
        int           win;
        bit           capped;
        avail  = rv;
        win    = -1;
        capped = 0;
        e      = '0;
        if (m_holder >= 0 && rv[m_holder] && lk) begin
            if (m_hcnt + 1 < MAX_HOLD) begin
                m_hcnt++;
                e[m_holder] = 1'b1;
                return;
            end
            capped          = 1;
            avail[m_holder] = 1'b0;
        end
        start = md ? m_ptr : 0;
        for (int i = 0; i < N; i++) begin
            if (win < 0 && avail[(start + i) % N]) win = (start + i) % N;
        end
        if (win < 0 && capped) win = m_holder;
        if (win < 0) begin
            m_holder = -1;
            m_hcnt   = 0;
        end else begin
            m_holder = win;
            m_hcnt   = 0;
            m_ptr    = (win + 1) % N;
            e[win]   = 1'b1;
        end
    endtask

    // Called just after a falling edge; asserts reset mid-cycle.
    task automatic reset_pulse(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs(tag, '0);
        m_holder = -1;
        m_ptr    = 0;
        m_hcnt   = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [0:N-1] rv;
        logic         md;
        logic         lk;
        logic [0:N-1] e;

        // 1: asynchronous reset with all requests active
        bus.r    = 4'b1111;
        bus.mode = 1'b0;
        bus.lock = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check_outputs("t1_reset", 4'b0000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step("t1_first", 4'b1111, 1'b0, 1'b0, 4'b1000);

        // 2: fixed priority, no lock
        step("t2_fix_a", 4'b0110, 1'b0, 1'b0, 4'b0100);
        step("t2_fix_b", 4'b0001, 1'b0, 1'b0, 4'b0001);
        step("t2_idle",  4'b0000, 1'b0, 1'b0, 4'b0000);

        // 3: round robin rotation with wrap (ptr is 0 here)
        step("t3_rr0", 4'b1111, 1'b1, 1'b0, 4'b1000);
        step("t3_rr1", 4'b1111, 1'b1, 1'b0, 4'b0100);
        step("t3_rr2", 4'b1111, 1'b1, 1'b0, 4'b0010);
        step("t3_rr3", 4'b1111, 1'b1, 1'b0, 4'b0001);
        step("t3_wrap", 4'b1111, 1'b1, 1'b0, 4'b1000);

        // 4: locked grant bounded by MAX_HOLD; bring ptr back to 0 first
        step("t4_setup", 4'b0001, 1'b0, 1'b0, 4'b0001);
        step("t4_idle",  4'b0000, 1'b0, 1'b0, 4'b0000);
        for (int i = 0; i < MAX_HOLD; i++) begin
            step("t4_hold", 4'b1100, 1'b1, 1'b1, 4'b1000);
        end
        step("t4_limit", 4'b1100, 1'b1, 1'b1, 4'b0100);
        // sole requester past the limit keeps being re-granted
        for (int i = 0; i < 6; i++) begin
            step("t4_solo", 4'b1000, 1'b1, 1'b1, 4'b1000);
        end
        // re-grant restarted the count: two more held edges, then a switch
        step("t4_rst_a", 4'b1100, 1'b1, 1'b1, 4'b1000);
        step("t4_rst_b", 4'b1100, 1'b1, 1'b1, 4'b1000);
        step("t4_rst_sw", 4'b1100, 1'b1, 1'b1, 4'b0100);

        // 5: holder 1 drops with ptr=2, round robin then fixed priority
        step("t5_rr_drop", 4'b0011, 1'b1, 1'b1, 4'b0010);
        step("t5_idle",    4'b0000, 1'b0, 1'b0, 4'b0000);
        step("t5_fix_g1",  4'b0100, 1'b0, 1'b0, 4'b0100);
        step("t5_fixdrop", 4'b0011, 1'b0, 1'b0, 4'b0010);

        // 6: random traffic against the reference model
        reset_pulse("t6_reset");
        rv = '0;
        md = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 49) == 0) begin
                reset_pulse("t6_reset");
            end
            if ($urandom_range(0, 3) != 0) rv = N'($urandom_range(0, (1 << N) - 1));
            if ($urandom_range(0, 7) == 0) md = ~md;
            lk = ($urandom_range(0, 3) != 0);
            model_step(rv, md, lk, e);
            step("t6_rand", rv, md, lk, e);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
